// File: rtl/maxi_full_burst_gen_if.sv
`default_nettype none
// ------------------------------------------------------------------
// maxi_full_burst_gen_if : AXI4-full channel bundle, master/slave views
// Revision 1.0
// ------------------------------------------------------------------
interface maxi_full_burst_gen_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface
`default_nettype wire

// File: rtl/maxi_full_burst_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// maxi_full_burst_gen : AXI4-full write-then-readback traffic checker
// Revision 1.0
// ------------------------------------------------------------------
module maxi_full_burst_gen #(
  parameter int                        C_M_ID_WIDTH   = 1,
  parameter int                        C_M_ADDR_WIDTH = 6,
  parameter int                        C_M_DATA_WIDTH = 32,
  parameter int                        C_M_BURST_LEN  = 4,
  parameter int                        C_M_NUM_BURSTS = 2,
  parameter logic [C_M_ADDR_WIDTH-1:0] C_M_BASE_ADDR  = '0,
  parameter logic [31:0]               C_M_DATA_SEED  = 32'h55
) (
  input  logic                  M_AXI_ACLK,
  input  logic                  M_AXI_ARESETN,
  input  logic                  INIT_TXN,
  output logic                  TXN_DONE,
  output logic                  ERROR,
  output logic [7:0]            ERR_COUNT,
  maxi_full_burst_gen_if.master m_axi
);
  localparam int                        BYTES      = C_M_DATA_WIDTH / 8;
  localparam logic [C_M_ADDR_WIDTH-1:0] STRIDE     = C_M_ADDR_WIDTH'(C_M_BURST_LEN * BYTES);
  localparam logic [8:0]                LAST_BEAT  = 9'(C_M_BURST_LEN - 1);
  localparam logic [8:0]                LAST_BURST = 9'(C_M_NUM_BURSTS - 1);
  localparam logic [C_M_DATA_WIDTH-1:0] SEED       = C_M_DATA_WIDTH'(C_M_DATA_SEED);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t                    state, state_nx;
  logic                      init_q;
  logic [8:0]                burst_idx, burst_nx, beat, beat_nx;
  logic [C_M_ADDR_WIDTH-1:0] addr, addr_nx;
  logic [C_M_DATA_WIDTH-1:0] data, data_nx;
  logic                      awvalid, awvalid_nx, wvalid, wvalid_nx, wlast, wlast_nx;
  logic                      bready, bready_nx, arvalid, arvalid_nx, rready, rready_nx;
  logic                      done, done_nx, error, error_nx, beat_err;
  logic [7:0]                err_cnt, err_cnt_nx;
  logic                      unused_ids;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state     <= S_IDLE;
      init_q    <= 1'b0;
      burst_idx <= '0;
      beat      <= '0;
      addr      <= C_M_BASE_ADDR;
      data      <= SEED;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      wlast     <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nx;
      init_q    <= INIT_TXN;
      burst_idx <= burst_nx;
      beat      <= beat_nx;
      addr      <= addr_nx;
      data      <= data_nx;
      awvalid   <= awvalid_nx;
      wvalid    <= wvalid_nx;
      wlast     <= wlast_nx;
      bready    <= bready_nx;
      arvalid   <= arvalid_nx;
      rready    <= rready_nx;
      done      <= done_nx;
      error     <= error_nx;
      err_cnt   <= err_cnt_nx;
    end
  end

  // data doubles as the write pattern and the read-back expectation
  always_comb begin
    state_nx   = state;
    burst_nx   = burst_idx;
    beat_nx    = beat;
    addr_nx    = addr;
    data_nx    = data;
    awvalid_nx = awvalid;
    wvalid_nx  = wvalid;
    wlast_nx   = wlast;
    bready_nx  = bready;
    arvalid_nx = arvalid;
    rready_nx  = rready;
    done_nx    = 1'b0;
    error_nx   = error;
    err_cnt_nx = err_cnt;
    beat_err   = 1'b0;
    case (state)
      S_IDLE: if (INIT_TXN && !init_q) begin
        state_nx   = S_AW;
        awvalid_nx = 1'b1;
        burst_nx   = '0;
        addr_nx    = C_M_BASE_ADDR;
        data_nx    = SEED;
        error_nx   = 1'b0;
        err_cnt_nx = '0;
      end
      S_AW: if (awvalid && m_axi.awready) begin
        awvalid_nx = 1'b0;
        wvalid_nx  = 1'b1;
        wlast_nx   = (LAST_BEAT == 9'd0);
        beat_nx    = '0;
        state_nx   = S_W;
      end
      S_W: if (wvalid && m_axi.wready) begin
        data_nx = data + 1'b1;
        if (wlast) begin
          wvalid_nx = 1'b0;
          wlast_nx  = 1'b0;
          bready_nx = 1'b1;
          state_nx  = S_B;
        end else begin
          beat_nx  = beat + 9'd1;
          wlast_nx = ((beat + 9'd1) == LAST_BEAT);
        end
      end
      S_B: if (bready && m_axi.bvalid) begin
        bready_nx = 1'b0;
        beat_err  = (m_axi.bresp != 2'b00);
        if (burst_idx == LAST_BURST) begin
          burst_nx   = '0;
          addr_nx    = C_M_BASE_ADDR;
          data_nx    = SEED;
          arvalid_nx = 1'b1;
          state_nx   = S_AR;
        end else begin
          burst_nx   = burst_idx + 9'd1;
          addr_nx    = addr + STRIDE;
          awvalid_nx = 1'b1;
          state_nx   = S_AW;
        end
      end
      S_AR: if (arvalid && m_axi.arready) begin
        arvalid_nx = 1'b0;
        rready_nx  = 1'b1;
        beat_nx    = '0;
        state_nx   = S_R;
      end
      S_R: if (rready && m_axi.rvalid) begin
        data_nx  = data + 1'b1;
        beat_nx  = beat + 9'd1;
        beat_err = (m_axi.rdata != data) || (m_axi.rresp != 2'b00) ||
                   (m_axi.rlast != (beat == LAST_BEAT));
        if (beat == LAST_BEAT) begin
          rready_nx = 1'b0;
          if (burst_idx == LAST_BURST) begin
            done_nx  = 1'b1;
            state_nx = S_DONE;
          end else begin
            burst_nx   = burst_idx + 9'd1;
            addr_nx    = addr + STRIDE;
            arvalid_nx = 1'b1;
            state_nx   = S_AR;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (beat_err) begin
      error_nx = 1'b1;
      if (err_cnt != 8'hFF) err_cnt_nx = err_cnt + 8'd1;
    end
  end

  assign m_axi.awid    = '0;
  assign m_axi.awaddr  = addr;
  assign m_axi.awlen   = 8'(C_M_BURST_LEN - 1);
  assign m_axi.awsize  = 3'($clog2(BYTES));
  assign m_axi.awburst = 2'b01;
  assign m_axi.awvalid = awvalid;
  assign m_axi.wdata   = data;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wlast;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = bready;
  assign m_axi.arid    = '0;
  assign m_axi.araddr  = addr;
  assign m_axi.arlen   = 8'(C_M_BURST_LEN - 1);
  assign m_axi.arsize  = 3'($clog2(BYTES));
  assign m_axi.arburst = 2'b01;
  assign m_axi.arvalid = arvalid;
  assign m_axi.rready  = rready;
  assign TXN_DONE      = done;
  assign ERROR         = error;
  assign ERR_COUNT     = err_cnt;
  assign unused_ids    = ^{m_axi.bid, m_axi.rid};
endmodule
`default_nettype wire

// File: tb/tb_maxi_full_burst_gen.sv
`default_nettype none
// tb_maxi_full_burst_gen : two generator instances against behavioural AXI slaves,
// checked against a beat-level reference model of the expected traffic.
module tb_maxi_full_burst_gen;
  localparam int          LEN   = 4;
  localparam int          NB    = 2;
  localparam int          LEN_B = 16;
  localparam logic [31:0] SEED  = 32'h55;

  logic       clk = 1'b0;
  logic       rst_n, init_a, init_b;
  logic       done_a, err_a, done_b, err_b;
  logic [7:0] cnt_a, cnt_b;
  int         total = 0, bad = 0;

  always #5 clk = ~clk;

  maxi_full_burst_gen_if #(.ID_WIDTH(1), .ADDR_WIDTH(6), .DATA_WIDTH(32)) ax ();
  maxi_full_burst_gen_if #(.ID_WIDTH(1), .ADDR_WIDTH(8), .DATA_WIDTH(64)) bx ();

  maxi_full_burst_gen dut_a (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .INIT_TXN(init_a),
    .TXN_DONE(done_a), .ERROR(err_a), .ERR_COUNT(cnt_a), .m_axi(ax.master));

  maxi_full_burst_gen #(.C_M_ADDR_WIDTH(8), .C_M_DATA_WIDTH(64),
                        .C_M_BURST_LEN(LEN_B), .C_M_NUM_BURSTS(1)) dut_b (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .INIT_TXN(init_b),
    .TXN_DONE(done_b), .ERROR(err_b), .ERR_COUNT(cnt_b), .m_axi(bx.master));

  // ---------------- slave A: stalling memory with fault injection ----------------
  int          stall = 0, bresp_bad = -1, cor_burst = -1, cor_beat = 0, el_burst = -1, el_beat = 0;
  logic [31:0] cor_xor = 32'h0;
  logic [31:0] mem_a [0:15];
  int          aw_wait, w_wait, ar_wait, wb_idx, rb_idx, rbeat;
  logic [3:0]  wptr, rptr;
  logic        bv_a, rv_a;
  logic [1:0]  br_a;
  logic [5:0]  aw_q[$], ar_q[$];
  logic [12:0] awattr_q[$], arattr_q[$];
  logic [31:0] wd_q[$];
  logic        wl_q[$];
  int          done_cyc_a = 0, done_cyc_b = 0, stab_viol = 0;

  assign ax.awready = ax.awvalid && (aw_wait >= stall);
  assign ax.wready  = ax.wvalid && (w_wait >= stall);
  assign ax.arready = ax.arvalid && (ar_wait >= stall);
  assign ax.bid     = '0;
  assign ax.bvalid  = bv_a;
  assign ax.bresp   = br_a;
  assign ax.rid     = '0;
  assign ax.rvalid  = rv_a;
  assign ax.rresp   = 2'b00;
  assign ax.rdata   = mem_a[rptr] ^ ((rb_idx == cor_burst && rbeat == cor_beat) ? cor_xor : 32'h0);
  assign ax.rlast   = (rb_idx == el_burst) ? (rbeat == el_beat) : (rbeat == LEN - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; wb_idx <= 0; rb_idx <= 0; rbeat <= 0;
      wptr <= '0; rptr <= '0; bv_a <= 1'b0; rv_a <= 1'b0; br_a <= 2'b00;
    end else begin
      aw_wait <= (ax.awvalid && !ax.awready) ? aw_wait + 1 : 0;
      w_wait  <= (ax.wvalid && !ax.wready) ? w_wait + 1 : 0;
      ar_wait <= (ax.arvalid && !ax.arready) ? ar_wait + 1 : 0;
      if (ax.awvalid && ax.awready) begin
        wptr   <= ax.awaddr[5:2];
        wb_idx <= int'(ax.awaddr[5:4]);
        aw_q.push_back(ax.awaddr);
        awattr_q.push_back({ax.awlen, ax.awsize, ax.awburst});
      end
      if (ax.wvalid && ax.wready) begin
        mem_a[wptr] <= ax.wdata;
        wptr        <= wptr + 4'd1;
        wd_q.push_back(ax.wdata);
        wl_q.push_back(ax.wlast);
        if (ax.wlast) begin
          bv_a <= 1'b1;
          br_a <= (wb_idx == bresp_bad) ? 2'b10 : 2'b00;
        end
      end
      if (bv_a && ax.bready) bv_a <= 1'b0;
      if (ax.arvalid && ax.arready) begin
        rptr   <= ax.araddr[5:2];
        rb_idx <= int'(ax.araddr[5:4]);
        rbeat  <= 0;
        rv_a   <= 1'b1;
        ar_q.push_back(ax.araddr);
        arattr_q.push_back({ax.arlen, ax.arsize, ax.arburst});
      end
      if (rv_a && ax.rready) begin
        rptr  <= rptr + 4'd1;
        rbeat <= rbeat + 1;
        if (rbeat == LEN - 1) rv_a <= 1'b0;
      end
    end
  end

  // held-while-stalled observer
  logic        p_aw, p_w, p_ar, p_wl;
  logic [5:0]  p_awa, p_ara;
  logic [31:0] p_wd;
  always @(posedge clk) begin
    if (rst_n)
      stab_viol <= stab_viol
        + int'(p_aw && (!ax.awvalid || ax.awaddr != p_awa))
        + int'(p_w && (!ax.wvalid || ax.wdata != p_wd || ax.wlast != p_wl))
        + int'(p_ar && (!ax.arvalid || ax.araddr != p_ara));
    p_aw  <= rst_n && ax.awvalid && !ax.awready;
    p_w   <= rst_n && ax.wvalid && !ax.wready;
    p_ar  <= rst_n && ax.arvalid && !ax.arready;
    p_awa <= ax.awaddr; p_ara <= ax.araddr; p_wd <= ax.wdata; p_wl <= ax.wlast;
    if (done_a) done_cyc_a <= done_cyc_a + 1;
    if (done_b) done_cyc_b <= done_cyc_b + 1;
  end

  // ---------------- slave B: ideal 64-bit memory ----------------
  logic [63:0] mem_b [0:31];
  logic [4:0]  bwp, brp;
  logic        bv_b, rv_b;
  int          bbeat, b_aw_n = 0;
  logic [20:0] b_aw_q[$];
  logic [63:0] bwd_q[$];
  logic        bwl_q[$];

  assign bx.awready = bx.awvalid;
  assign bx.wready  = bx.wvalid;
  assign bx.arready = bx.arvalid;
  assign bx.bid     = '0;
  assign bx.bresp   = 2'b00;
  assign bx.bvalid  = bv_b;
  assign bx.rid     = '0;
  assign bx.rresp   = 2'b00;
  assign bx.rvalid  = rv_b;
  assign bx.rdata   = mem_b[brp];
  assign bx.rlast   = (bbeat == LEN_B - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bwp <= '0; brp <= '0; bv_b <= 1'b0; rv_b <= 1'b0; bbeat <= 0;
    end else begin
      if (bx.awvalid) begin
        bwp    <= bx.awaddr[7:3];
        b_aw_n <= b_aw_n + 1;
        b_aw_q.push_back({bx.awaddr, bx.awlen, bx.awsize, bx.awburst});
      end
      if (bx.wvalid) begin
        mem_b[bwp] <= bx.wdata;
        bwp        <= bwp + 5'd1;
        bwd_q.push_back(bx.wdata);
        bwl_q.push_back(bx.wlast);
        if (bx.wlast) bv_b <= 1'b1;
      end
      if (bv_b && bx.bready) bv_b <= 1'b0;
      if (bx.arvalid) begin
        brp <= bx.araddr[7:3]; bbeat <= 0; rv_b <= 1'b1;
      end
      if (rv_b && bx.rready) begin
        brp <= brp + 5'd1; bbeat <= bbeat + 1;
        if (bbeat == LEN_B - 1) rv_b <= 1'b0;
      end
    end
  end

  // ---------------- checking helpers and reference model ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // every beat with at least one fault costs one error, plus one per bad BRESP
  function automatic int exp_errs();
    int n = 0;
    for (int b = 0; b < NB; b++) begin
      if (b == bresp_bad) n++;
      for (int k = 0; k < LEN; k++)
        if ((b == cor_burst && k == cor_beat) || (b == el_burst && (k == el_beat || k == LEN - 1)))
          n++;
    end
    return (n > 255) ? 255 : n;
  endfunction

  task automatic run_a(output bit ok, output int aw0, output int w0, output int ar0, output int d0);
    aw0 = aw_q.size(); w0 = wd_q.size(); ar0 = ar_q.size(); d0 = done_cyc_a; ok = 1'b0;
    @(negedge clk) init_a = 1'b1;
    @(negedge clk) init_a = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_cyc_a != d0) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_a(input string t, input bit ok, input int aw0, input int w0,
                         input int ar0, input int d0, input int exp_e);
    logic [12:0] attr;
    attr = {8'(LEN - 1), 3'd2, 2'b01};
    chk({t, ":done_seen"}, 64'(ok), 64'd1);
    chk({t, ":aw_count"}, 64'(aw_q.size() - aw0), 64'(NB));
    chk({t, ":ar_count"}, 64'(ar_q.size() - ar0), 64'(NB));
    chk({t, ":w_count"}, 64'(wd_q.size() - w0), 64'(NB * LEN));
    for (int b = 0; b < NB; b++) begin
      if (aw0 + b < aw_q.size()) begin
        chk({t, ":awaddr"}, 64'(aw_q[aw0 + b]), 64'(b * LEN * 4));
        chk({t, ":aw_len_size_burst"}, 64'(awattr_q[aw0 + b]), 64'(attr));
      end
      if (ar0 + b < ar_q.size()) begin
        chk({t, ":araddr"}, 64'(ar_q[ar0 + b]), 64'(b * LEN * 4));
        chk({t, ":ar_len_size_burst"}, 64'(arattr_q[ar0 + b]), 64'(attr));
      end
    end
    for (int i = 0; i < NB * LEN; i++)
      if (w0 + i < wd_q.size()) begin
        chk({t, ":wdata"}, 64'(wd_q[w0 + i]), 64'(SEED + 32'(i)));
        chk({t, ":wlast"}, 64'(wl_q[w0 + i]), 64'((i % LEN) == LEN - 1));
      end
    chk({t, ":done_cycles"}, 64'(done_cyc_a - d0), 64'd1);
    chk({t, ":error"}, 64'(err_a), 64'(exp_e > 0));
    chk({t, ":err_count"}, 64'(cnt_a), 64'(exp_e));
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    bit ok;
    int aw0, w0, ar0, d0, n, seen;
    rst_n = 1'b0; init_a = 1'b0; init_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_a", 64'({ax.awvalid, ax.wvalid, ax.wlast, ax.bready, ax.arvalid,
                                ax.rready, done_a, err_a, cnt_a}), 64'd0);
    chk("reset_outputs_b", 64'({bx.awvalid, bx.wvalid, bx.wlast, bx.arvalid, done_b, err_b, cnt_b}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_a(ok, aw0, w0, ar0, d0);
    check_a("ideal", ok, aw0, w0, ar0, d0, exp_errs());

    stall = 3;
    run_a(ok, aw0, w0, ar0, d0);
    check_a("stall3", ok, aw0, w0, ar0, d0, exp_errs());
    chk("stall3:held_while_stalled", 64'(stab_viol), 64'd0);

    stall = 0; bresp_bad = 0; cor_burst = 1; cor_beat = 2; cor_xor = 32'h5B;
    run_a(ok, aw0, w0, ar0, d0);
    check_a("corrupt_bresp", ok, aw0, w0, ar0, d0, 2);

    bresp_bad = -1; cor_burst = -1; el_burst = 0; el_beat = 2;
    run_a(ok, aw0, w0, ar0, d0);
    check_a("early_rlast", ok, aw0, w0, ar0, d0, 2);

    for (int it = 0; it < 4; it++) begin
      stall     = int'($urandom_range(0, 3));
      bresp_bad = int'($urandom_range(0, 2));
      cor_burst = int'($urandom_range(0, 2));
      cor_beat  = int'($urandom_range(0, 3));
      cor_xor   = $urandom | 32'h1;
      el_burst  = int'($urandom_range(0, 2));
      el_beat   = int'($urandom_range(0, 2));
      run_a(ok, aw0, w0, ar0, d0);
      check_a("random", ok, aw0, w0, ar0, d0, exp_errs());
    end
    chk("random:held_while_stalled", 64'(stab_viol), 64'd0);

    // reset in the middle of the first write burst
    stall = 2; bresp_bad = -1; cor_burst = -1; el_burst = -1;
    @(negedge clk) init_a = 1'b1;
    @(negedge clk) init_a = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ax.wvalid) begin seen = 1; break; end
    end
    chk("rst_mid_w:reached_w", 64'(seen), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_w:async_outputs", 64'({ax.awvalid, ax.wvalid, ax.wlast, ax.bready, ax.arvalid,
                                         ax.rready, done_a, err_a, cnt_a}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ax.awvalid || ax.wvalid || ax.arvalid) n++;
    end
    chk("rst_mid_w:stays_idle", 64'(n), 64'd0);
    run_a(ok, aw0, w0, ar0, d0);
    check_a("after_reset", ok, aw0, w0, ar0, d0, 0);

    // wide-bus long burst, with a second start request while reading
    w0 = bwd_q.size(); aw0 = b_aw_n; d0 = done_cyc_b; seen = 0; ok = 1'b0;
    @(negedge clk) init_b = 1'b1;
    @(negedge clk) init_b = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bx.rvalid && bx.rready) begin seen = 1; break; end
    end
    chk("b:read_started", 64'(seen), 64'd1);
    @(negedge clk) init_b = 1'b1;
    @(negedge clk) init_b = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_cyc_b != d0) begin ok = 1'b1; break; end
    end
    repeat (40) @(negedge clk);
    chk("b:done_seen", 64'(ok), 64'd1);
    chk("b:done_cycles", 64'(done_cyc_b - d0), 64'd1);
    chk("b:aw_count", 64'(b_aw_n - aw0), 64'd1);
    if (aw0 < b_aw_q.size())
      chk("b:aw_addr_len_size_burst", 64'(b_aw_q[aw0]), 64'({8'h00, 8'd15, 3'd3, 2'b01}));
    chk("b:w_count", 64'(bwd_q.size() - w0), 64'(LEN_B));
    for (int k = 0; k < LEN_B; k++)
      if (w0 + k < bwd_q.size()) begin
        chk("b:wdata", bwd_q[w0 + k], 64'(SEED) + 64'(k));
        chk("b:wlast", 64'(bwl_q[w0 + k]), 64'(k == LEN_B - 1));
      end
    chk("b:error", 64'(err_b), 64'd0);
    chk("b:err_count", 64'(cnt_b), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/maxi_full_burst_gen.md
Name: maxi_full_burst_gen

Overview:
- Synthesizable AXI4-full master that generates traffic and self-checks. It replaces hand-written bench masters.
- On start it writes C_M_NUM_BURSTS INCR bursts of C_M_BURST_LEN beats with a deterministic data pattern. It then reads the same region back, compares every beat, and reports done/error.
- Sits in front of any AXI4-full slave, including our slave memory, in both simulation and on-board bring-up.

Parameters:
- C_M_ID_WIDTH, 1, width of AWID/ARID/BID/RID.
- C_M_ADDR_WIDTH, 6, address bus width.
- C_M_DATA_WIDTH, 32, data bus width; must be 32, 64 or 128.
- C_M_BURST_LEN, 4, beats per burst; legal range 1..256.
- C_M_NUM_BURSTS, 2, bursts per phase; legal range 1..256.
- C_M_BASE_ADDR, 0, byte address of the first burst; must be aligned to C_M_DATA_WIDTH/8.
- C_M_DATA_SEED, 32'h55, first data word; zero-extended to C_M_DATA_WIDTH.

Ports:
- M_AXI_ACLK  in  1  clock; all logic on rising edge.
- M_AXI_ARESETN  in  1  asynchronous active-low reset.
- INIT_TXN  in  1  start request; a rising edge is the trigger.
- TXN_DONE  out  1  one-cycle pulse when the check completes.
- ERROR  out  1  sticky error flag; cleared on the next start.
- ERR_COUNT  out  8  saturating count of failed beats and responses.
- M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN[7:0], M_AXI_AWSIZE[2:0], M_AXI_AWBURST[1:0], M_AXI_AWVALID  out; M_AXI_AWREADY  in.
- M_AXI_WDATA, M_AXI_WSTRB[DATA_WIDTH/8], M_AXI_WLAST, M_AXI_WVALID  out; M_AXI_WREADY  in.
- M_AXI_BID, M_AXI_BRESP[1:0], M_AXI_BVALID  in; M_AXI_BREADY  out.
- M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID  out; M_AXI_ARREADY  in.
- M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP[1:0], M_AXI_RLAST, M_AXI_RVALID  in; M_AXI_RREADY  out.

Behaviour:
- Reset (M_AXI_ARESETN low, asynchronous):
  - All VALID/READY/LAST outputs, TXN_DONE, ERROR and ERR_COUNT go to 0.
  - All counters clear, addresses return to C_M_BASE_ADDR, FSM goes to IDLE.
  - Reset mid-burst abandons the transaction; the slave must also be reset.
- Constant outputs: ID = 0; AxLEN = C_M_BURST_LEN-1; AxSIZE = log2(DATA_WIDTH/8); AxBURST = 2'b01 (INCR); WSTRB all ones.
- FSM states: IDLE, AW, W, B, AR, R, DONE.
  - IDLE -> AW on INIT_TXN rising edge, detected from a registered copy of INIT_TXN. The same edge clears ERROR, ERR_COUNT and burst_idx.
  - INIT_TXN edges outside IDLE are ignored.
- Burst address: BASE + burst_idx * BURST_LEN * (DATA_WIDTH/8), truncated to ADDR_WIDTH. The integrator guarantees no 4 KB crossing.
- AW state:
  - AWVALID is registered and held high with a stable address until AWREADY; it drops the cycle after the handshake.
  - Then -> W. Only one burst is outstanding at a time.
- W state:
  - WVALID high. Beat k of burst b carries SEED + b*BURST_LEN + k, modulo 2^DATA_WIDTH.
  - Data advances only on WVALID & WREADY. WLAST is high exactly on beat BURST_LEN-1.
  - When WREADY is low, data/WLAST hold.
  - After the last-beat handshake, WVALID drops -> B.
- B state:
  - BREADY high until BVALID; then BREADY drops.
  - BRESP != 2'b00 sets ERROR and increments ERR_COUNT.
  - If more bursts remain: burst_idx+1 -> AW. Else: burst_idx = 0 -> AR.
- AR state: same rules as AW on the read channel -> R.
- R state:
  - RREADY high. Each RVALID & RREADY beat is compared to the same expected pattern.
  - These each count as one error (ERR_COUNT +1, ERROR set): data mismatch; RRESP != 0; RLAST asserted on a beat other than BURST_LEN-1; RLAST missing on beat BURST_LEN-1.
  - A single beat with several faults counts once.
  - On the final beat (by count), RREADY drops. If more bursts remain -> AR with the next burst, else -> DONE.
- DONE: TXN_DONE high for exactly one cycle -> IDLE. ERROR and ERR_COUNT hold until the next start.
- ERR_COUNT saturates at 255 and does not wrap.
- Beat counter: 9 bits, so BURST_LEN = 256 is legal. Burst counter: 9 bits.
- The block never asserts a VALID combinationally from a READY.

Test Plan:
- Defaults, ideal slave memory, INIT_TXN pulse:
  - AW at 0x00 then 0x10, AWLEN = 3, AWSIZE = 2, AWBURST = 1.
  - WDATA 0x55..0x5C; WLAST on the 4th and 8th beats.
  - Reads return the same values; TXN_DONE pulses once; ERROR = 0; ERR_COUNT = 0.
- Slave stalls AWREADY/WREADY/ARREADY for 3 cycles each:
  - AWADDR, WDATA and WLAST stay stable while stalled.
  - Identical beat sequence; ERR_COUNT = 0.
- Slave corrupts read beat 2 of burst 1 (returns 0x00 instead of 0x5B) and returns BRESP = 2'b10 on burst 0:
  - ERROR = 1; ERR_COUNT = 2 at TXN_DONE.
- Slave asserts RLAST on beat 2 of a 4-beat burst:
  - ERR_COUNT increments by 2: the early RLAST on beat 2 and the missing RLAST on beat 3.
- Reset asserted during the W state of burst 0:
  - All outputs are 0 immediately, asynchronously.
  - After release with no INIT_TXN edge, the FSM stays in IDLE; a new pulse runs a clean pass.
- BURST_LEN = 16, NUM_BURSTS = 1, DATA_WIDTH = 64:
  - AWLEN = 15, AWSIZE = 3, 16 beats with WLAST on beat 15.
  - Second INIT_TXN pulse mid-read is ignored; TXN_DONE pulses once.
